// File: rtl/div_pkg.sv
// Shared definitions for the sequential 2N/N restoring divider.
// Contents:
//   state_t      - controller states (IDLE, BUSY, DONE)
//   QUOT_SAT_BIT - bit replicated N times to form the saturated quotient
//   cnt_width()  - width of the iteration counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Quotient returned for divide-by-zero and overflow is all ones.
  localparam logic QUOT_SAT_BIT = 1'b1;

  // The counter runs from n-1 down to 0, so it must hold values up to n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   r_in     [N:0]   partial remainder before the step (always < divisor)
//   bit_in           next dividend bit shifted in from the quotient register
//   divisor  [N-1:0] denominator
//   r_out    [N:0]   partial remainder after the step
//   q_bit            quotient bit produced by this step
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic         q_bit
);

  // r_in[N] is always zero because the remainder stays below the divisor,
  // so shifting the whole r_in gives the same trial value as {r_in[N-1:0], bit_in}.
  logic [N+1:0] trial;
  logic [N+1:0] dvs_ext;

  assign trial   = {r_in, bit_in};
  assign dvs_ext = (N+2)'(divisor);

  // Subtract the divisor only when it fits; otherwise restore (keep trial).
  always_comb begin
    r_out = (N+1)'(trial);
    q_bit = 1'b0;
    if (trial >= dvs_ext) begin
      r_out = (N+1)'(trial - dvs_ext);
      q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/div_64_32_32.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit
// quotient and remainder, one quotient bit per clock, valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready is a register, high in IDLE)
//   dividend [2N-1:0]     numerator, sampled only on the accepting edge
//   divisor  [N-1:0]      denominator, sampled only on the accepting edge
//   out_valid / out_ready result handshake
//   quotient, remainder   result (held stable until drained)
//   div_by_zero           divisor was zero (quotient saturated)
//   overflow              quotient would not fit in N bits (quotient saturated)
module div_64_32_32
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int             CW       = cnt_width(N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [N-1:0]   QUOT_SAT = {N{QUOT_SAT_BIT}};

  state_t        state;
  logic [N:0]    rem_q;
  logic [N-1:0]  shift_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] count;

  logic [N:0]    step_r;
  logic          step_bit;

  // The shift register doubles as the dividend-low source (MSB first) and
  // the quotient collector (LSB in), so one step unit does all the work.
  div_step #(.N(N)) u_step (
    .r_in    (rem_q),
    .bit_in  (shift_q[N-1]),
    .divisor (dvs_q),
    .r_out   (step_r),
    .q_bit   (step_bit)
  );

  // Controller and datapath registers. Special cases (zero divisor, quotient
  // overflow) are resolved on the accepting edge and skip the BUSY loop.
  // A non-overflowing divide has dividend_hi < divisor, which is what keeps
  // the partial remainder below the divisor on every iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
      rem_q       <= '0;
      shift_q     <= '0;
      dvs_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            dvs_q    <= divisor;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= QUOT_SAT;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (dividend[2*N-1:N] >= divisor) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= QUOT_SAT;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              state   <= BUSY;
              rem_q   <= {1'b0, dividend[2*N-1:N]};
              shift_q <= dividend[N-1:0];
              count   <= CNT_LAST;
            end
          end
        end

        BUSY: begin
          rem_q   <= step_r;
          shift_q <= {shift_q[N-2:0], step_bit};
          if (count == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= {shift_q[N-2:0], step_bit};
            remainder   <= N'(step_r);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_64_32_32.sv
// Randomised, scoreboard-checked bench for div_64_32_32 (N = 32).
module tb_div_64_32_32;

  localparam int N = 32;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int bpMode  = 0;

  div_64_32_32 #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: always ready, randomly stalling, or left to the main thread.
  always @(posedge clk) begin
    #2;
    if (bpMode == 0) out_ready = 1'b1;
    else if (bpMode == 2) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: plain 64-bit division; saturate when the divisor is zero or
  // the true quotient needs more than N bits. Latency is counted in clock
  // edges after the accepting edge (special cases are visible right away).
  function automatic exp_t refModel(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    exp_t e;
    logic [2*N-1:0] q64;
    logic [2*N-1:0] r64;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (dvs == '0) begin
      e.q = '1; e.r = dvd[N-1:0]; e.dbz = 1'b1; e.lat = 0;
    end else begin
      q64 = dvd / {32'd0, dvs};
      r64 = dvd % {32'd0, dvs};
      if (q64 > 64'h0000_0000_FFFF_FFFF) begin
        e.q = '1; e.r = dvd[N-1:0]; e.ovf = 1'b1; e.lat = 0;
      end else begin
        e.q = q64[N-1:0]; e.r = r64[N-1:0]; e.lat = N;
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    int   waitCount;
    exp_t e;
    @(negedge clk);
    waitCount = 0;
    while (!in_ready && waitCount < 2000) begin
      @(negedge clk);
      waitCount++;
    end
    if (!in_ready) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
    end else begin
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      e        = refModel(dvd, dvs);
      e.acc    = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
    end
  endtask

  // Monitor: latency on the first valid cycle, stability while stalled,
  // and full result comparison on the draining cycle.
  logic         prevValid = 1'b0;
  logic [N-1:0] holdQ, holdR;
  logic         holdD, holdO;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (out_valid) begin
        checkOutput("in_ready_while_valid", 64'(in_ready), 64'd0);
        if (!prevValid) begin
          if (sb.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_output: q=0x%0h r=0x%0h, expected no result", quotient, remainder);
          end else begin
            checkOutput("latency", 64'(cyc - sb[0].acc - 1), 64'(sb[0].lat));
          end
          holdQ = quotient; holdR = remainder; holdD = div_by_zero; holdO = overflow;
        end else begin
          checkOutput("hold_quotient", 64'(quotient), 64'(holdQ));
          checkOutput("hold_remainder", 64'(remainder), 64'(holdR));
          checkOutput("hold_flags", 64'({div_by_zero, overflow}), 64'({holdD, holdO}));
        end
        if (out_ready && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("quotient", 64'(quotient), 64'(e.q));
          checkOutput("remainder", 64'(remainder), 64'(e.r));
          checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          checkOutput("overflow", 64'(overflow), 64'(e.ovf));
        end
      end
      prevValid = out_valid;
    end
  end

  task automatic checkResetState();
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_quotient", 64'(quotient), 64'd0);
    checkOutput("rst_remainder", 64'(remainder), 64'd0);
    checkOutput("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
  endtask

  initial begin
    int waitCount;
    logic [N-1:0] a, b;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    #12;
    checkResetState();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including the N-bit quotient boundary.
    applyStimulus(64'd42, 32'd7);
    applyStimulus(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 32'h10);
    applyStimulus(64'h1234, 32'd0);
    applyStimulus(64'h0000_0001_0000_0000, 32'd1);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 32'd1);
    applyStimulus(64'h0000_0000_FFFF_FFFF, 32'h0000_0000_FFFF_FFFF);

    // Backpressure: stall 10 cycles, wiggle in_valid, then drain.
    waitCount = 0;
    while (sb.size() != 0 && waitCount < 2000) begin @(negedge clk); waitCount++; end
    bpMode = 1;
    @(posedge clk); #2; out_ready = 1'b0;
    applyStimulus(64'd1000, 32'd3);
    waitCount = 0;
    while (!out_valid && waitCount < 100) begin @(negedge clk); waitCount++; end
    checkOutput("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_drained_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_drained_ready", 64'(in_ready), 64'd1);
    bpMode = 0;

    // Reset in the middle of a divide (counter at 15): abort, no result.
    applyStimulus(64'h0000_0005_1234_5678, 32'h9ABC_DEF0);
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkResetState();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(64'd100, 32'd9);

    // Round trip with the multiplier under random backpressure.
    bpMode = 2;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (b == '0) b = 32'd1;
      applyStimulus(64'(a) * 64'(b), b);
    end
    // Unconstrained operands, mostly exercising overflow and zero divisors.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = (i % 7 == 0) ? 32'd0 : $urandom;
      applyStimulus({$urandom, a}, b);
    end

    bpMode = 0;
    waitCount = 0;
    while (sb.size() != 0 && waitCount < 2000) begin @(negedge clk); waitCount++; end
    if (sb.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
